multdiv_sequencer: RTL and testbench

//  Sequences the shared multi-cycle multiply/divide unit for the 5-stage pipeline.

---
 rtl/multdiv_sequencer_pkg.sv | 34 +++
 rtl/multdiv_sequencer_watchdog.sv | 32 +++
 rtl/multdiv_sequencer.sv | 115 +++++++++++
 tb/tb_multdiv_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// Shared encodings and payload types for the multiply/divide sequencer.
package multdiv_sequencer_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FIELD_W = 5;

  localparam logic [FIELD_W-1:0] OPC_RTYPE   = 5'b00000;
  localparam logic [FIELD_W-1:0] ALUOP_MUL   = 5'b00110;
  localparam logic [FIELD_W-1:0] ALUOP_DIV   = 5'b00111;
  localparam logic [REG_W-1:0]   REG_RSTATUS = 5'd30;
  localparam logic [XLEN-1:0]    EXC_MUL     = 32'd4;
  localparam logic [XLEN-1:0]    EXC_DIV     = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  typedef struct packed {
    logic              is_div;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } md_req_t;

  function automatic logic is_multdiv(input logic [FIELD_W-1:0] opcode,
                                      input logic [FIELD_W-1:0] aluop);
    return (opcode == OPC_RTYPE) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
  endfunction

endpackage

// File: rtl/multdiv_sequencer_watchdog.sv
// BUSY-cycle watchdog for the multdiv sequencer; only built with MULTDIV_TIMEOUT_EN.
`ifdef MULTDIV_TIMEOUT_EN
module multdiv_sequencer_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic busy,
  output logic timeout_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Saturating count of BUSY cycles since the last issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (busy && (cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Fires during the last allowed BUSY cycle so DONE follows exactly TIMEOUT_CYCLES BUSY cycles.
  assign timeout_c = busy && (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/multdiv_sequencer.sv
// Stalls the pipeline around the shared multi-cycle mul/div unit and writes its result back.
// Optional BUSY timeout enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             dx_valid,
  input  logic [31:0]      dx_insn,
  input  logic [31:0]      dx_a,
  input  logic [31:0]      dx_b,
  input  logic             flush,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic [31:0]      md_a,
  output logic [31:0]      md_b,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_rdy,
  output logic             stall,
  output logic             dx_squash,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data
);

  md_state_t state;
  md_req_t   req;

  logic [FIELD_W-1:0] opcode;
  logic [FIELD_W-1:0] aluop;
  logic               start_c;
  logic               timeout_c;
  logic               md_done_c;
  logic               md_fail_c;
  logic               unused_insn_bits;

  assign opcode           = dx_insn[31:27];
  assign aluop            = dx_insn[6:2];
  assign unused_insn_bits = ^{dx_insn[21:7], dx_insn[1:0]};

  // Reset gates start so stall is low the moment reset asserts.
  assign start_c = reset && (state == ST_IDLE) && dx_valid && !flush && is_multdiv(opcode, aluop);
  assign stall   = start_c || (state == ST_ISSUE) || (state == ST_BUSY);

  assign md_a = req.a;
  assign md_b = req.b;

`ifdef MULTDIV_TIMEOUT_EN
  multdiv_sequencer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clock),
    .rst_n     (reset),
    .clear     (state == ST_ISSUE),
    .busy      (state == ST_BUSY),
    .timeout_c (timeout_c)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout_c = 1'b0;
`endif

  // A timeout without md_rdy is reported as an exception.
  assign md_done_c = md_rdy || timeout_c;
  assign md_fail_c = md_rdy ? md_exception : 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      req          <= '0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      dx_squash    <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      dx_squash    <= 1'b0;
      wb_valid     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_c) begin
            req.is_div   <= (aluop == ALUOP_DIV);
            req.rd       <= dx_insn[26:22];
            req.a        <= dx_a;
            req.b        <= dx_b;
            md_ctrl_mult <= (aluop != ALUOP_DIV);
            md_ctrl_div  <= (aluop == ALUOP_DIV);
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_BUSY;
        ST_BUSY: begin
          if (md_done_c) begin
            wb_valid  <= 1'b1;
            dx_squash <= 1'b1;
            wb_rd     <= md_fail_c ? REG_RSTATUS : req.rd;
            wb_data   <= md_fail_c ? (req.is_div ? EXC_DIV : EXC_MUL) : md_result;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dx_valid = 1'b0;
  logic [31:0] dx_insn = '0;
  logic [31:0] dx_a = '0;
  logic [31:0] dx_b = '0;
  logic        flush = 1'b0;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_rdy = 1'b0;
  logic        stall;
  logic        dx_squash;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad = 0;
  int cycle_no = 0;

  multdiv_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .dx_valid     (dx_valid),
    .dx_insn      (dx_insn),
    .dx_a         (dx_a),
    .dx_b         (dx_b),
    .flush        (flush),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_a         (md_a),
    .md_b         (md_b),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_rdy       (md_rdy),
    .stall        (stall),
    .dx_squash    (dx_squash),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle_no <= cycle_no + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [4:0] aluop, input logic [4:0] rd);
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
  endfunction

  // Starts an op at the current negedge (sequencer in IDLE) and plays the unit's rdy d cycles after ISSUE.
  task automatic run_op(input string name, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input int d, input logic [31:0] res,
                        input logic exc, input logic [4:0] exp_rd, input logic [31:0] exp_data,
                        input logic is_div, input int exp_stalls, input logic nxt_valid,
                        input logic [31:0] nxt_insn, output int issue_at, output int wb_at);
    int stalls = 1;
    int mults = 0;
    int divs = 0;
    logic got_wb = 1'b0;
    issue_at = 0;
    wb_at = 0;
    dx_valid = 1'b1;
    dx_insn = insn;
    dx_a = a;
    dx_b = b;
    #1;
    check({name, "_start_stall"}, 32'(stall), 32'd1);
    for (int cyc = 1; cyc <= 40 && !got_wb; cyc++) begin
      @(negedge clock);
      if (md_ctrl_mult) mults++;
      if (md_ctrl_div) divs++;
      if (md_ctrl_mult || md_ctrl_div) issue_at = cycle_no;
      if (cyc == 1) begin
        check({name, "_md_a"}, md_a, a);
        check({name, "_md_b"}, md_b, b);
      end
      if (wb_valid) begin
        got_wb = 1'b1;
        wb_at = cycle_no;
        check({name, "_wb_rd"}, 32'(wb_rd), 32'(exp_rd));
        check({name, "_wb_data"}, wb_data, exp_data);
        check({name, "_squash"}, 32'(dx_squash), 32'd1);
        check({name, "_done_stall"}, 32'(stall), 32'd0);
        dx_valid = nxt_valid;
        dx_insn = nxt_insn;
      end else if (stall) begin
        stalls++;
      end
      md_rdy = (cyc == 1 + d);
      md_result = res;
      md_exception = exc && (cyc == 1 + d);
    end
    md_rdy = 1'b0;
    md_exception = 1'b0;
    check({name, "_wb_seen"}, 32'(got_wb), 32'd1);
    check({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    check({name, "_mult_pulses"}, 32'(mults), is_div ? 32'd0 : 32'd1);
    check({name, "_div_pulses"}, 32'(divs), is_div ? 32'd1 : 32'd0);
  endtask

  initial begin
    int ia1, wa1, ia2, wa2;
    logic [31:0] nop;
    nop = '0;

    // Reset state
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ctrl", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_md_a", md_a, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // mul r3 = 7*3, rdy 4 cycles after ISSUE
    run_op("t1_mul", mk_insn(5'b00110, 5'd3), 32'd7, 32'd3, 4, 32'd21, 1'b0,
           5'd3, 32'd21, 1'b0, 6, 1'b0, nop, ia1, wa1);
    @(negedge clock);

    // div r4 = 9/0 -> exception into rstatus
    run_op("t2_div0", mk_insn(5'b00111, 5'd4), 32'd9, 32'd0, 2, 32'hdead_beef, 1'b1,
           5'd30, 32'd5, 1'b1, 4, 1'b0, nop, ia1, wa1);
    @(negedge clock);

    // Flushed mul never starts
    dx_valid = 1'b1;
    dx_insn = mk_insn(5'b00110, 5'd9);
    flush = 1'b1;
    #1;
    check("t3_flush_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t3_flush_ctrl", 32'({md_ctrl_mult, md_ctrl_div, stall}), 32'd0);
    end
    dx_valid = 1'b0;
    flush = 1'b0;
    @(negedge clock);

    // Back-to-back mul r6 then div r7, minimum latency on the first
    run_op("t4_mul", mk_insn(5'b00110, 5'd6), 32'd6, 32'd7, 1, 32'd42, 1'b0,
           5'd6, 32'd42, 1'b0, 3, 1'b1, mk_insn(5'b00111, 5'd7), ia1, wa1);
    @(negedge clock);
    run_op("t4_div", mk_insn(5'b00111, 5'd7), 32'd100, 32'd7, 3, 32'd14, 1'b0,
           5'd7, 32'd14, 1'b1, 5, 1'b0, nop, ia2, wa2);
    check("t4_b2b_gap", 32'(ia2 - wa1), 32'd2);
    @(negedge clock);

    // mul into r0 still pulses wb_valid
    run_op("t_rd0", mk_insn(5'b00110, 5'd0), 32'd5, 32'd5, 2, 32'd25, 1'b0,
           5'd0, 32'd25, 1'b0, 4, 1'b0, nop, ia1, wa1);
    @(negedge clock);

    // Reset asserted in BUSY
    dx_valid = 1'b1;
    dx_insn = mk_insn(5'b00110, 5'd2);
    dx_a = 32'd11;
    dx_b = 32'd13;
    @(negedge clock);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_stall", 32'(stall), 32'd0);
    check("t5_rst_ctrl", 32'({md_ctrl_mult, md_ctrl_div, dx_squash, wb_valid}), 32'd0);
    check("t5_rst_md_a", md_a, 32'd0);
    check("t5_rst_wb_data", wb_data, 32'd0);
    @(negedge clock);
    dx_valid = 1'b0;
    md_rdy = 1'b1;
    md_result = 32'd143;
    reset = 1'b1;
    @(negedge clock);
    md_rdy = 1'b0;
    check("t5_late_rdy_wb", 32'(wb_valid), 32'd0);
    check("t5_late_rdy_stall", 32'(stall), 32'd0);
    @(negedge clock);
    run_op("t5_after", mk_insn(5'b00110, 5'd8), 32'd2, 32'd8, 2, 32'd16, 1'b0,
           5'd8, 32'd16, 1'b0, 4, 1'b0, nop, ia1, wa1);
    @(negedge clock);

`ifdef MULTDIV_TIMEOUT_EN
    // md_rdy never rises: forced mul exception after 8 BUSY cycles
    run_op("t6_timeout", mk_insn(5'b00110, 5'd5), 32'd1, 32'd2, -1, 32'd0, 1'b0,
           5'd30, 32'd4, 1'b0, 10, 1'b0, nop, ia1, wa1);
    @(negedge clock);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
